// File: rtl/wb_common_pkg.sv
// Shared Wishbone definitions: CTI/BTE codes, arbiter state type and small helper functions.
package wb_common_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic {StIdle, StBusy} arb_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [3:0] onehot2bin(input logic [15:0] oh);
    logic [3:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) b = b | 4'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/wb_rr_prio_enc.sv
// Round-robin priority encoder: first set request at or after ptr, wrapping modulo N.
module wb_rr_prio_enc #(
  parameter int unsigned N    = 2,
  parameter int unsigned PtrW = 1
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic            valid
);

  int unsigned idx;
  logic        found;

  // Walking the rotated order is equivalent to rotate / find-first / unrotate.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone B3 round-robin arbiter with whole-cycle locking.
// Optional slave watchdog enabled by defining WB_RR_ARBITER_TIMEOUT_EN.
module wb_rr_arbiter
  import wb_common_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int unsigned SW   = DW / 8;
  localparam int unsigned PtrW = (NUM_MASTERS > 1) ? clog2(NUM_MASTERS) : 1;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PtrW-1:0]        ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] enc_gnt;
  logic                   enc_valid;
  logic [3:0]             owner_idx;
  logic                   to_err;
  logic                   cyc_m, stb_m, we_m;
  logic [AW-1:0]          adr_m;
  logic [DW-1:0]          dat_m;
  logic [SW-1:0]          sel_m;
  logic [2:0]             cti_m;
  logic [1:0]             bte_m;

  wb_rr_prio_enc #(
    .N    (NUM_MASTERS),
    .PtrW (PtrW)
  ) u_prio_enc (
    .req   (wbm_cyc_i),
    .ptr   (ptr_q),
    .gnt   (enc_gnt),
    .valid (enc_valid)
  );

  assign owner_idx = onehot2bin(16'(grant_q));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (enc_valid) begin
          grant_d = enc_gnt;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!(|(wbm_cyc_i & grant_q))) begin
          grant_d = '0;
          state_d = StIdle;
          ptr_d   = (owner_idx == 4'(NUM_MASTERS - 1)) ? '0 : PtrW'(owner_idx + 4'd1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // AND-OR mux; a zero grant (idle or reset) forces every slave-side output low.
  always_comb begin
    cyc_m = 1'b0;
    stb_m = 1'b0;
    we_m  = 1'b0;
    adr_m = '0;
    dat_m = '0;
    sel_m = '0;
    cti_m = '0;
    bte_m = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        cyc_m = cyc_m | wbm_cyc_i[i];
        stb_m = stb_m | wbm_stb_i[i];
        we_m  = we_m | wbm_we_i[i];
        adr_m = adr_m | wbm_adr_i[i*AW +: AW];
        dat_m = dat_m | wbm_dat_i[i*DW +: DW];
        sel_m = sel_m | wbm_sel_i[i*SW +: SW];
        cti_m = cti_m | wbm_cti_i[i*3 +: 3];
        bte_m = bte_m | wbm_bte_i[i*2 +: 2];
      end
    end
  end

  assign wbs_cyc_o = cyc_m;
  assign wbs_stb_o = stb_m & ~to_err;
  assign wbs_we_o  = we_m;
  assign wbs_adr_o = adr_m;
  assign wbs_dat_o = dat_m;
  assign wbs_sel_o = sel_m;
  assign wbs_cti_o = cti_m;
  assign wbs_bte_o = bte_m;

  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
  assign wbm_ack_o = grant_q & {NUM_MASTERS{wbs_ack_i}};
  assign wbm_err_o = grant_q & {NUM_MASTERS{wbs_err_i | to_err}};
  assign wbm_rty_o = grant_q & {NUM_MASTERS{wbs_rty_i}};
  assign grant_o   = grant_q;

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        to_err_q, to_err_d;
  logic        resp, stalled;

  assign resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign stalled = wbs_cyc_o & wbs_stb_o & ~resp;

  always_comb begin
    cnt_d    = cnt_q;
    to_err_d = 1'b0;
    if (state_q != StBusy || state_d != StBusy || resp) begin
      cnt_d = '0;
    end else if (stalled) begin
      if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
        cnt_d    = '0;
        to_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q    <= '0;
      to_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign to_err = to_err_q & (state_q == StBusy);
`else
  assign to_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: cycle-level ownership model plus directed scenarios.
module tb_wb_rr_arbiter;
  import wb_common_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int T  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] m_adr [N];
  logic [DW-1:0] m_dat [N];
  logic [SW-1:0] m_sel [N];
  logic [2:0]    m_cti [N];
  logic [1:0]    m_bte [N];
  logic [N-1:0]  m_we, m_cyc, m_stb;

  logic [N*AW-1:0] wbm_adr;
  logic [N*DW-1:0] wbm_dat;
  logic [N*SW-1:0] wbm_sel;
  logic [N*3-1:0]  wbm_cti;
  logic [N*2-1:0]  wbm_bte;
  logic [N*DW-1:0] wbm_dat_o;
  logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o, grant;
  logic [AW-1:0]   wbs_adr;
  logic [DW-1:0]   wbs_dat, wbs_dat_i;
  logic [SW-1:0]   wbs_sel;
  logic            wbs_we, wbs_cyc, wbs_stb;
  logic [2:0]      wbs_cti;
  logic [1:0]      wbs_bte;
  logic            auto_ack, s_err, s_rty, wbs_ack;

  assign wbs_ack   = auto_ack & wbs_cyc & wbs_stb;
  assign wbs_dat_i = 32'hCAFE_F00D;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      wbm_adr[i*AW +: AW] = m_adr[i];
      wbm_dat[i*DW +: DW] = m_dat[i];
      wbm_sel[i*SW +: SW] = m_sel[i];
      wbm_cti[i*3 +: 3]   = m_cti[i];
      wbm_bte[i*2 +: 2]   = m_bte[i];
    end
  end

  wb_rr_arbiter #(
    .NUM_MASTERS    (N),
    .AW             (AW),
    .DW             (DW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbm_adr_i (wbm_adr),
    .wbm_dat_i (wbm_dat),
    .wbm_sel_i (wbm_sel),
    .wbm_we_i  (m_we),
    .wbm_cyc_i (m_cyc),
    .wbm_stb_i (m_stb),
    .wbm_cti_i (wbm_cti),
    .wbm_bte_i (wbm_bte),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_o (wbm_ack_o),
    .wbm_err_o (wbm_err_o),
    .wbm_rty_o (wbm_rty_o),
    .wbs_adr_o (wbs_adr),
    .wbs_dat_o (wbs_dat),
    .wbs_sel_o (wbs_sel),
    .wbs_we_o  (wbs_we),
    .wbs_cyc_o (wbs_cyc),
    .wbs_stb_o (wbs_stb),
    .wbs_cti_o (wbs_cti),
    .wbs_bte_o (wbs_bte),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_i (wbs_ack),
    .wbs_err_i (s_err),
    .wbs_rty_i (s_rty),
    .grant_o   (grant)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Ownership model: who owns the bus after each edge, from the arbitration rules only.
  int m_owner, m_ptr, m_cnt;
  bit m_to;

  always @(posedge clk or negedge rst_n) begin : model
    int o, p, c;
    bit to;
    if (!rst_n) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_cnt   <= 0;
      m_to    <= 1'b0;
    end else begin
      o  = m_owner;
      p  = m_ptr;
      c  = m_cnt;
      to = 1'b0;
      if (m_owner < 0) begin
        c = 0;
        for (int k = 0; k < N; k++) begin
          if (o < 0 && m_cyc[(m_ptr + k) % N]) o = (m_ptr + k) % N;
        end
      end else if (!m_cyc[m_owner]) begin
        p = (m_owner + 1) % N;
        o = -1;
        c = 0;
      end else begin
`ifdef WB_RR_ARBITER_TIMEOUT_EN
        if (wbs_ack || s_err || s_rty) c = 0;
        else if (m_stb[m_owner] && !m_to) begin
          if (c == T - 1) begin
            c  = 0;
            to = 1'b1;
          end else c = c + 1;
        end
`endif
      end
      m_owner <= o;
      m_ptr   <= p;
      m_cnt   <= c;
      m_to    <= to;
    end
  end

  always @(negedge clk) begin : cmp
    logic [N-1:0] eg;
    bit own, ecyc;
    eg  = '0;
    own = (m_owner >= 0);
    if (own) eg[m_owner] = 1'b1;
    ecyc = own && m_cyc[m_owner];
    check("grant", 128'(grant), 128'(eg));
    check("wbs_cyc", 128'(wbs_cyc), 128'(ecyc));
    check("wbs_stb", 128'(wbs_stb), 128'(ecyc && m_stb[m_owner] && !m_to));
    check("wbs_adr", 128'(wbs_adr), own ? 128'(m_adr[m_owner]) : 128'(0));
    check("wbs_dat", 128'(wbs_dat), own ? 128'(m_dat[m_owner]) : 128'(0));
    check("wbs_sel", 128'(wbs_sel), own ? 128'(m_sel[m_owner]) : 128'(0));
    check("wbs_we", 128'(wbs_we), own ? 128'(m_we[m_owner]) : 128'(0));
    check("wbs_cti", 128'(wbs_cti), own ? 128'(m_cti[m_owner]) : 128'(0));
    check("wbs_bte", 128'(wbs_bte), own ? 128'(m_bte[m_owner]) : 128'(0));
    check("wbm_ack", 128'(wbm_ack_o), 128'(wbs_ack ? eg : '0));
    check("wbm_err", 128'(wbm_err_o), 128'((s_err || m_to) ? eg : '0));
    check("wbm_rty", 128'(wbm_rty_o), 128'(s_rty ? eg : '0));
    check("wbm_dat", 128'(wbm_dat_o), 128'({N{wbs_dat_i}}));
  end

  int ack_cnt [N];
  initial for (int i = 0; i < N; i++) ack_cnt[i] = 0;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) if (wbm_ack_o[i]) ack_cnt[i] <= ack_cnt[i] + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic idle_all();
    m_cyc = '0;
    m_stb = '0;
  endtask

  int n, errs, base0, base1;
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < N; i++) begin
      m_adr[i] = 32'h1000_0000 + 32'(i * 16);
      m_dat[i] = 32'hD000_0000 | 32'(i);
      m_sel[i] = 4'(i + 1);
      m_cti[i] = CTI_CLASSIC;
      m_bte[i] = BTE_LINEAR;
    end
    m_we = 4'b1010;
    idle_all();
    auto_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    #12;
    check("reset_grant", 128'(grant), 128'(0));
    check("reset_wbs_cyc", 128'(wbs_cyc), 128'(0));
    rst_n = 1'b1;
    tick();

    // Single request from master 1.
    m_adr[1] = 32'h9000_0004;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    #1;
    check("t1_no_cyc_before_edge", 128'(wbs_cyc), 128'(0));
    tick();
    check("t1_grant", 128'(grant), 128'(4'b0010));
    check("t1_cyc", 128'(wbs_cyc), 128'(1));
    check("t1_adr", 128'(wbs_adr), 128'(32'h9000_0004));
    auto_ack = 1'b1;
    #1;
    check("t1_ack_route", 128'(wbm_ack_o), 128'(4'b0010));
    tick();
    idle_all();
    auto_ack = 1'b0;
    tick();
    check("t1_release", 128'(grant), 128'(0));

    // Fairness from a fresh pointer.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    m_cyc = '1;
    m_stb = '1;
    auto_ack = 1'b1;
    for (int g = 0; g < 5; g++) begin
      int o;
      n = 0;
      while (grant == '0 && n < 20) begin
        tick();
        n++;
      end
      o = oh_idx(grant);
      check("t2_order", 128'(o), 128'(exp_order[g]));
      check("t2_gap", 128'(n), 128'(1));
      tick();
      m_cyc[o] = 1'b0;
      m_stb[o] = 1'b0;
      tick();
      if (g < 4) begin
        m_cyc[o] = 1'b1;
        m_stb[o] = 1'b1;
      end else idle_all();
    end
    auto_ack = 1'b0;
    tick();

    // Burst lock: m0 8-beat incrementing wrap-8 while m1 waits.
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    m_cti[0] = CTI_INC;
    m_bte[0] = BTE_WRAP8;
    tick();
    check("t3_grant_m0", 128'(grant), 128'(4'b0001));
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    auto_ack = 1'b1;
    base0 = ack_cnt[0];
    base1 = ack_cnt[1];
    for (int b = 0; b < 8; b++) begin
      m_cti[0] = (b == 7) ? CTI_EOB : CTI_INC;
      #1;
      check("t3_cti", 128'(wbs_cti), (b == 7) ? 128'(3'b111) : 128'(3'b010));
      check("t3_bte", 128'(wbs_bte), 128'(2'b10));
      check("t3_locked", 128'(grant), 128'(4'b0001));
      tick();
    end
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    m_cti[0] = CTI_CLASSIC;
    m_bte[0] = BTE_LINEAR;
    auto_ack = 1'b0;
    #1;
    check("t3_m0_acks", 128'(ack_cnt[0] - base0), 128'(8));
    check("t3_m1_acks", 128'(ack_cnt[1] - base1), 128'(0));
    tick();
    check("t3_idle_gap", 128'(grant), 128'(0));
    tick();
    check("t3_grant_m1", 128'(grant), 128'(4'b0010));
    idle_all();
    tick();
    tick();

    // Reset in the middle of a burst.
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    m_cti[0] = CTI_INC;
    auto_ack = 1'b1;
    tick();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t4_async_cyc", 128'(wbs_cyc), 128'(0));
    check("t4_async_grant", 128'(grant), 128'(0));
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    auto_ack = 1'b0;
    m_cti[0] = CTI_CLASSIC;
    tick();
    rst_n = 1'b1;
    tick();
    check("t4_first_grant_m0", 128'(grant), 128'(4'b0001));
    idle_all();
    tick();
    tick();

    // Silent slave.
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    tick();
`ifdef WB_RR_ARBITER_TIMEOUT_EN
    n = 0;
    while (wbm_err_o[0] == 1'b0 && n < 100) begin
      tick();
      n++;
    end
    check("t5_stall_cycles", 128'(n), 128'(T));
    check("t5_err", 128'(wbm_err_o), 128'(4'b0001));
    check("t5_stb_forced_low", 128'(wbs_stb), 128'(0));
    tick();
    check("t5_err_one_cycle", 128'(wbm_err_o), 128'(0));
    check("t5_stb_back", 128'(wbs_stb), 128'(1));
`else
    errs = 0;
    repeat (1000) begin
      tick();
      if (wbm_err_o != '0) errs++;
    end
    check("t5_no_err", 128'(errs), 128'(0));
`endif

    // Error and retry pass-through with a waiting bystander.
    m_cyc[2] = 1'b1;
    m_stb[2] = 1'b1;
    s_err = 1'b1;
    #1;
    check("t6_err", 128'(wbm_err_o), 128'(4'b0001));
    s_err = 1'b0;
    s_rty = 1'b1;
    #1;
    check("t6_rty", 128'(wbm_rty_o), 128'(4'b0001));
    check("t6_no_ack", 128'(wbm_ack_o), 128'(0));
    s_rty = 1'b0;
    idle_all();
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout, want finish");
    $fatal(1);
  end

endmodule
